// File: rtl/serial_capture.sv
// serial_capture: reassembles MSB-first serial bursts from NCH channels into left-aligned frames.
// Optional GRAY2BIN_EN: frame_data is gray-decoded as it is registered.
module serial_capture #(
   parameter int DATA_W = 128,
   parameter int CNT_W  = 16,
   parameter int NCH    = 8
)(
   input  logic                                  clk_out16x,
   input  logic                                  rst,
   input  logic [NCH-1:0]                        data_in_ch,
   input  logic [NCH-1:0]                        data_vld_ch,
   output logic                                  frame_valid,
   output logic [DATA_W-1:0]                     frame_data,
   output logic [CNT_W-1:0]                      frame_len,
   output logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] frame_ch,
   output logic                                  frame_ovf,
   output logic                                  frame_err,
   output logic                                  busy
);
   localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;
   localparam int AW   = $clog2(DATA_W);
   localparam logic [CNT_W-1:0] DW_CNT = CNT_W'(DATA_W);

   typedef enum logic {IDLE, RECV} state_t;
   state_t state, state_nxt;

   logic [DATA_W-1:0] work_q, frame_nxt;
   logic [CNT_W-1:0]  cnt_q;
   logic [CH_W-1:0]   ch_q, vld_idx;
   logic              ovf_q, err_q;
   logic              vld_onehot, vld_k, vld_other;
   logic              start, take, done;
   logic [AW-1:0]     pos;

   always_comb begin
      vld_idx = '0;
      for (int i = 0; i < NCH; i++)
         if (data_vld_ch[i]) vld_idx = CH_W'(i);
   end

   assign vld_onehot = (data_vld_ch != '0) &&
                       ((data_vld_ch & (data_vld_ch - NCH'(1))) == '0);
   assign vld_k      = data_vld_ch[ch_q];
   assign vld_other  = |(data_vld_ch & ~(NCH'(1) << ch_q));
   // Only meaningful while cnt_q < DATA_W; beyond that bits are counted, not stored.
   assign pos        = AW'(DATA_W - 1) - cnt_q[AW-1:0];
   assign busy       = (state == RECV);

   always_ff @(posedge clk_out16x) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      start     = 1'b0;
      take      = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: if (vld_onehot) begin
            start     = 1'b1;
            state_nxt = RECV;
         end
         RECV: if (vld_k) take = 1'b1;
               else begin
                  done      = 1'b1;
                  state_nxt = IDLE;
               end
         default: state_nxt = IDLE;
      endcase
   end

`ifdef GRAY2BIN_EN
   always_comb begin
      logic acc;
      acc       = 1'b0;
      frame_nxt = '0;
      for (int i = DATA_W - 1; i >= 0; i--) begin
         acc          = acc ^ work_q[i];
         frame_nxt[i] = acc;
      end
   end
`else
   assign frame_nxt = work_q;
`endif

   always_ff @(posedge clk_out16x) begin
      if (rst) begin
         work_q      <= '0;
         cnt_q       <= '0;
         ch_q        <= '0;
         ovf_q       <= 1'b0;
         err_q       <= 1'b0;
         frame_valid <= 1'b0;
         frame_data  <= '0;
         frame_len   <= '0;
         frame_ch    <= '0;
         frame_ovf   <= 1'b0;
         frame_err   <= 1'b0;
      end else begin
         frame_valid <= done;
         if (start) begin
            work_q <= {data_in_ch[vld_idx], {(DATA_W-1){1'b0}}};
            cnt_q  <= CNT_W'(1);
            ch_q   <= vld_idx;
            ovf_q  <= 1'b0;
            err_q  <= 1'b0;
         end
         if (take) begin
            if (cnt_q < DW_CNT) work_q[pos] <= data_in_ch[ch_q];
            else                ovf_q       <= 1'b1;
            if (cnt_q != '1)    cnt_q       <= cnt_q + CNT_W'(1);
            err_q <= err_q | vld_other;
         end
         if (done) begin
            frame_data <= frame_nxt;
            frame_len  <= cnt_q;
            frame_ch   <= ch_q;
            frame_ovf  <= ovf_q;
            frame_err  <= err_q | vld_other;
         end
      end
   end
endmodule

// File: tb/tb_serial_capture.sv
// Bench for serial_capture: directed bursts, a frame-level model queue and per-cycle compare.
module tb_serial_capture;
   localparam int DATA_W = 128, CNT_W = 16, NCH = 8;

   logic              clk = 1'b0;
   logic              rst;
   logic [NCH-1:0]    din, vld;
   logic              frame_valid, frame_ovf, frame_err, busy;
   logic [DATA_W-1:0] frame_data;
   logic [CNT_W-1:0]  frame_len;
   logic [2:0]        frame_ch;

   serial_capture #(.DATA_W(DATA_W), .CNT_W(CNT_W), .NCH(NCH)) dut (
      .clk_out16x(clk), .rst(rst), .data_in_ch(din), .data_vld_ch(vld),
      .frame_valid(frame_valid), .frame_data(frame_data), .frame_len(frame_len),
      .frame_ch(frame_ch), .frame_ovf(frame_ovf), .frame_err(frame_err), .busy(busy));

   always #5 clk = ~clk;

   typedef struct {
      longint       cyc;
      logic [127:0] data;
      int           len;
      int           ch;
      bit           ovf;
      bit           err;
   } frame_t;

   frame_t exp_q[$];
   longint cyc = 0;
   int     n_pass = 0, n_tot = 0;
   bit     chk_en = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   // Expected frame from the list of bits the sender put on the wire.
   function automatic frame_t model(input longint c, input logic [255:0] bits, input int n,
                                    input int ch, input bit err);
      frame_t       f;
      logic [127:0] d;
      bit           acc;
      d   = '0;
      acc = 0;
      for (int i = 0; i < n && i < DATA_W; i++) d[DATA_W-1-i] = bits[255-i];
`ifdef GRAY2BIN_EN
      for (int i = DATA_W - 1; i >= 0; i--) begin
         acc  = acc ^ d[i];
         d[i] = acc;
      end
`endif
      f.cyc  = c;
      f.data = d;
      f.len  = (n > 65535) ? 65535 : n;
      f.ch   = ch;
      f.ovf  = (n > DATA_W);
      f.err  = err;
      return f;
   endfunction

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk); #1;
         vld = '0;
         din = '0;
      end
   endtask

   // Sends n bits on channel ch (first bit at bits[255]); fch/fat inject a foreign
   // valid at bit fat; end_vld is the valid vector driven on the end sample.
   task automatic burst(input int ch, input int n, input logic [255:0] bits,
                        input int fch, input int fat, input logic [NCH-1:0] end_vld);
      bit err;
      err = 0;
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         vld     = NCH'(1) << ch;
         din     = '0;
         din[ch] = bits[255-i];
         if (fch >= 0 && i == fat) begin
            vld[fch] = 1'b1;
            din[fch] = ~bits[255-i];
            err      = 1;
         end
         @(negedge clk);
         chk("busy in burst", busy, (i > 0));
      end
      @(posedge clk); #1;
      vld = end_vld;
      din = '0;
      if (end_vld != '0) err = 1;
      exp_q.push_back(model(cyc + 1, bits, n, ch, err));
      @(negedge clk);
      chk("busy on end sample", busy, (n > 0));
   endtask

   initial begin
      frame_t e;
      forever begin
         @(negedge clk);
         if (chk_en) begin
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
               e = exp_q.pop_front();
               chk("frame_valid pulse", frame_valid, 1);
               chk("frame_data", frame_data, e.data);
               chk("frame_len", frame_len, e.len);
               chk("frame_ch", frame_ch, e.ch);
               chk("frame_ovf", frame_ovf, e.ovf);
               chk("frame_err", frame_err, e.err);
            end else begin
               chk("frame_valid quiet", frame_valid, 0);
            end
         end
      end
   end

   initial begin
      rst = 1'b1;
      vld = '0;
      din = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("reset frame_valid", frame_valid, 0);
      chk("reset frame_data", frame_data, 0);
      chk("reset frame_len", frame_len, 0);
      chk("reset frame_ch", frame_ch, 0);
      chk("reset frame_ovf", frame_ovf, 0);
      chk("reset frame_err", frame_err, 0);
      chk("reset busy", busy, 0);
      chk_en = 1;

      // ch3, 8 bits 1011_0010
      burst(2, 8, {8'hB2, 248'b0}, -1, 0, '0);
      idle(2);
      chk("t1 ch", frame_ch, 2);
      chk("t1 len", frame_len, 8);
`ifdef GRAY2BIN_EN
      chk("t1 data", frame_data, {8'hDC, 120'b0});
`else
      chk("t1 data", frame_data, {8'hB2, 120'b0});
`endif

      // full 128-bit burst on ch8, then ch1 back-to-back
      burst(7, 128, {128'h0123456789ABCDEF0123456789ABCDEF, 128'b0}, -1, 0, '0);
      burst(0, 4, {4'hF, 252'b0}, -1, 0, '0);
      idle(2);
      chk("t2 len", frame_len, 4);
      chk("t2 ch", frame_ch, 0);
`ifdef GRAY2BIN_EN
      chk("t2 data", frame_data, {4'hA, 124'b0});
`else
      chk("t2 data", frame_data, {4'hF, 124'b0});
`endif

      // 130-bit overflow burst on ch1
      burst(0, 130, {128'hA5A55A5A0F0FF0F0123456789ABCDEF0, 2'b11, 126'b0}, -1, 0, '0);
      idle(2);
      chk("t3 len", frame_len, 130);
      chk("t3 ovf", frame_ovf, 1);
`ifndef GRAY2BIN_EN
      chk("t3 data", frame_data, 128'hA5A55A5A0F0FF0F0123456789ABCDEF0);
`endif

      // ch2 burst with ch5 valid mid-burst
      burst(1, 10, {10'b1100110011, 246'b0}, 4, 5, '0);
      idle(2);
      chk("t4 err", frame_err, 1);
      chk("t4 ch", frame_ch, 1);
      chk("t4 ovf", frame_ovf, 0);

      // multi-hot in IDLE is ignored
      @(posedge clk); #1;
      vld = 8'h05;
      din = 8'h05;
      @(negedge clk);
      idle(1);
      @(negedge clk);
      chk("t4 multihot busy", busy, 0);
      idle(2);

      // foreign one-hot valid on the end sample: flagged, not started
      burst(5, 3, {3'b101, 253'b0}, -1, 0, 8'h40);
      burst(3, 6, {6'b011010, 250'b0}, -1, 0, '0);
      idle(2);

      // reset at bit 40 of a ch4 burst
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         vld = 8'h08;
         din = (i % 3 == 0) ? 8'h08 : 8'h00;
      end
      @(posedge clk); #1;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      vld = '0;
      din = '0;
      @(negedge clk);
      chk("t5 frame_data", frame_data, 0);
      chk("t5 frame_len", frame_len, 0);
      chk("t5 frame_ch", frame_ch, 0);
      chk("t5 frame_err", frame_err, 0);
      chk("t5 frame_ovf", frame_ovf, 0);
      chk("t5 busy", busy, 0);
      idle(2);
      burst(3, 8, {8'h3C, 248'b0}, -1, 0, '0);
      idle(2);
      chk("t5 clean ch", frame_ch, 3);
      chk("t5 clean len", frame_len, 8);

      // 2-bit burst 11
      burst(4, 2, {2'b11, 254'b0}, -1, 0, '0);
      idle(2);
`ifdef GRAY2BIN_EN
      chk("t6 data", frame_data, {4'h8, 124'b0});
`else
      chk("t6 data", frame_data, {4'hC, 124'b0});
`endif
      chk("t6 len", frame_len, 2);

      idle(3);
      chk("pending frames", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end
endmodule
